// File: rtl/mv_fifo.sv
// mv_fifo: DEPTH-entry first-word-fall-through FIFO of packed (h, v) motion vectors.
// Optional build-time macro MV_CLAMP_EN saturates each component to +/-MV_LIMIT on write.
module mv_fifo #(
  parameter int COMP_W   = 4,
  parameter int DEPTH    = 4,
  parameter int MV_LIMIT = 7
) (
  input  logic                     CLK,
  input  logic                     RST_ASYNC_N,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [2*COMP_W-1:0]      IN_MV,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [2*COMP_W-1:0]      OUT_MV,
  output logic signed [COMP_W-1:0] OUT_MV_H,
  output logic signed [COMP_W-1:0] OUT_MV_V,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     CLAMP_HIT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = 2 * COMP_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [MW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [MW-1:0] wr_data;
  logic [MW-1:0] head;
  logic          push;
  logic          pop;

  // Handshake flags depend on stored state only, so neither side sees a
  // combinational path from the other side's inputs.
  assign IN_READY  = (count != FULL_CNT);
  assign OUT_VALID = (count != '0);
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;
  assign COUNT     = count;

  assign head     = OUT_VALID ? mem[rd_ptr] : '0;
  assign OUT_MV   = head;
  assign OUT_MV_H = head[MW-1:COMP_W];
  assign OUT_MV_V = head[COMP_W-1:0];

`ifdef MV_CLAMP_EN
  localparam logic signed [COMP_W-1:0] LIM  = COMP_W'(MV_LIMIT);
  localparam logic signed [COMP_W-1:0] NLIM = -LIM;

  logic signed [COMP_W-1:0] h_in;
  logic signed [COMP_W-1:0] v_in;
  logic signed [COMP_W-1:0] h_sat;
  logic signed [COMP_W-1:0] v_sat;
  logic                     clamp_chg;
  logic                     clamp_hit_q;

  // Components saturate independently; the most negative code lands on -LIM.
  always_comb begin
    h_in  = IN_MV[MW-1:COMP_W];
    v_in  = IN_MV[COMP_W-1:0];
    h_sat = h_in;
    v_sat = v_in;
    if (h_in > LIM)       h_sat = LIM;
    else if (h_in < NLIM) h_sat = NLIM;
    if (v_in > LIM)       v_sat = LIM;
    else if (v_in < NLIM) v_sat = NLIM;
    wr_data   = {h_sat, v_sat};
    clamp_chg = (wr_data != IN_MV);
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      clamp_hit_q <= 1'b0;
    end else begin
      clamp_hit_q <= push && clamp_chg && !FLUSH;
    end
  end

  assign CLAMP_HIT = clamp_hit_q;
`else
  assign wr_data   = IN_MV;
  assign CLAMP_HIT = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (FLUSH) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
